relu_maxpool: RTL and testbench

//   Post-convolution stage: reads a finished 1-D feature map from the conv output RAM.

---
 rtl/relu_maxpool.sv | 158 +++++++++++++++
 tb/tb_relu_maxpool.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/relu_maxpool.sv
// relu_maxpool: post-convolution stage. Streams a finished 1-D feature map out of the
// conv output RAM, applies optional ReLU and non-overlapping max-pooling (window = stride =
// POOL_SIZE), and writes the pooled map into the next layer's input RAM. A start/done
// handshake lets a top-level sequencer chain it behind the convolution stage.
//
// Ports
//   clk      rising-edge clock
//   rst      asynchronous reset, active low
//   start    1-cycle run request, sampled only in IDLE
//   data_rd  source RAM read data, valid one cycle after addr_rd
//   addr_rd  source RAM read address (0 whenever idle)
//   data_wr  pooled result (registered, holds between writes)
//   addr_wr  destination RAM write address (registered, holds between writes)
//   wren     destination RAM write enable, one cycle per result
//   busy     high from the cycle after start through the done cycle
//   done     one-cycle pulse after the last result has been written

module relu_maxpool #(
  parameter int unsigned INPUT_SIZE    = 128,
  parameter int unsigned POOL_SIZE     = 2,
  parameter int unsigned BIT_WIDTH     = 16,
  parameter int unsigned IN_RAM_DEPTH  = 128,
  parameter int unsigned OUT_RAM_DEPTH = 64,
  parameter bit          RELU_EN       = 1'b1,
  localparam int unsigned RdAw = (IN_RAM_DEPTH > 1) ? $clog2(IN_RAM_DEPTH) : 1,
  localparam int unsigned WrAw = (OUT_RAM_DEPTH > 1) ? $clog2(OUT_RAM_DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [BIT_WIDTH-1:0] data_rd,
  output logic [RdAw-1:0]      addr_rd,
  output logic [BIT_WIDTH-1:0] data_wr,
  output logic [WrAw-1:0]      addr_wr,
  output logic                 wren,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned NumOut = INPUT_SIZE / POOL_SIZE;
  localparam int unsigned PosW   = (POOL_SIZE > 2) ? $clog2(POOL_SIZE) : 1;
  localparam int unsigned CntW   = $clog2(NumOut + 1);

  // Elaboration-time parameter checks
  if (INPUT_SIZE % POOL_SIZE != 0) begin : g_chk_multiple
    $error("relu_maxpool: INPUT_SIZE must be a multiple of POOL_SIZE");
  end
  if (INPUT_SIZE > IN_RAM_DEPTH) begin : g_chk_in_depth
    $error("relu_maxpool: INPUT_SIZE exceeds IN_RAM_DEPTH");
  end
  if (NumOut > OUT_RAM_DEPTH) begin : g_chk_out_depth
    $error("relu_maxpool: INPUT_SIZE/POOL_SIZE exceeds OUT_RAM_DEPTH");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e                      state_q;
  logic                        rd_valid_q;   // data_rd carries a requested sample this cycle
  logic [PosW-1:0]             pos_q;        // position of the incoming sample in its window
  logic signed [BIT_WIDTH-1:0] max_q;        // running max of the current window
  logic [CntW-1:0]             wr_cnt_q;     // results written so far in this run

  logic signed [BIT_WIDTH-1:0] sample;
  logic signed [BIT_WIDTH-1:0] win_max;
  logic signed [BIT_WIDTH-1:0] pool_res;
  logic                        last_rd;
  logic                        win_last;

  assign sample   = $signed(data_rd);
  assign last_rd  = (addr_rd == RdAw'(INPUT_SIZE - 1));
  assign win_last = (pos_q == PosW'(POOL_SIZE - 1));

  // The first sample of a window seeds the max, so no sentinel value is ever needed.
  always_comb begin
    win_max = sample;
    if ((pos_q != '0) && (max_q > sample)) begin
      win_max = max_q;
    end
    pool_res = win_max;
    if (RELU_EN && win_max[BIT_WIDTH-1]) begin
      pool_res = '0;
    end
  end

  // Control FSM: read address generation and handshake outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      addr_rd    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      done       <= 1'b0;
      rd_valid_q <= (state_q == StRun);
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StRun;
            busy    <= 1'b1;
            addr_rd <= '0;
          end
        end
        StRun: begin
          if (last_rd) begin
            state_q <= StDrain;
            addr_rd <= '0;
          end else begin
            addr_rd <= addr_rd + RdAw'(1);
          end
        end
        StDrain: begin
          // wr_cnt_q has already counted the write being presented this cycle
          if (wren && (wr_cnt_q == CntW'(NumOut))) begin
            state_q <= StDone;
            done    <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Pooling datapath and registered write port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos_q    <= '0;
      max_q    <= '0;
      wr_cnt_q <= '0;
      wren     <= 1'b0;
      data_wr  <= '0;
      addr_wr  <= '0;
    end else begin
      wren <= 1'b0;
      if (state_q == StIdle) begin
        pos_q    <= '0;
        wr_cnt_q <= '0;
      end
      if (rd_valid_q) begin
        if (win_last) begin
          pos_q    <= '0;
          wren     <= 1'b1;
          data_wr  <= pool_res;
          addr_wr  <= WrAw'(wr_cnt_q);
          wr_cnt_q <= wr_cnt_q + CntW'(1);
        end else begin
          pos_q <= pos_q + PosW'(1);
          max_q <= win_max;
        end
      end
    end
  end

endmodule

// File: tb/tb_relu_maxpool.sv
// Scoreboard bench for relu_maxpool. Three instances share clock and reset:
//   u0: default parameters (128 samples, pool 2, ReLU)
//   u1: 8 samples, pool 2, no ReLU
//   u2: 8 samples, pool 4, ReLU
// The driver pushes expected writes (address, value, cycle) computed from the RAM contents
// at start time; a negedge monitor pops and compares as the DUTs present results.

module tb_relu_maxpool;

  typedef struct {
    int                 addr;
    logic signed [15:0] data;
    int                 cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic start_big, start_sm;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [6:0]  ar0;
  logic [5:0]  aw0;
  logic [2:0]  ar1, ar2;
  logic [1:0]  aw1;
  logic [0:0]  aw2;
  logic [15:0] rd0, rd1, rd2, dw0, dw1, dw2;
  logic        wr0, wr1, wr2, bz0, bz1, bz2, dn0, dn1, dn2;

  logic signed [15:0] mem [3][128];

  always @(posedge clk) begin
    rd0 <= mem[0][ar0];
    rd1 <= mem[1][ar1];
    rd2 <= mem[2][ar2];
  end

  relu_maxpool u0 (
    .clk(clk), .rst(rst), .start(start_big), .data_rd(rd0), .addr_rd(ar0),
    .data_wr(dw0), .addr_wr(aw0), .wren(wr0), .busy(bz0), .done(dn0)
  );

  relu_maxpool #(
    .INPUT_SIZE(8), .POOL_SIZE(2), .IN_RAM_DEPTH(8), .OUT_RAM_DEPTH(4), .RELU_EN(1'b0)
  ) u1 (
    .clk(clk), .rst(rst), .start(start_sm), .data_rd(rd1), .addr_rd(ar1),
    .data_wr(dw1), .addr_wr(aw1), .wren(wr1), .busy(bz1), .done(dn1)
  );

  relu_maxpool #(
    .INPUT_SIZE(8), .POOL_SIZE(4), .IN_RAM_DEPTH(8), .OUT_RAM_DEPTH(2), .RELU_EN(1'b1)
  ) u2 (
    .clk(clk), .rst(rst), .start(start_sm), .data_rd(rd2), .addr_rd(ar2),
    .data_wr(dw2), .addr_wr(aw2), .wren(wr2), .busy(bz2), .done(dn2)
  );

  int n_in [3] = '{128, 8, 8};
  int p_sz [3] = '{2, 2, 4};
  bit relu [3] = '{1'b1, 1'b0, 1'b1};

  exp_t q0[$], q1[$], q2[$];
  int   exp_done [3];
  int   b_lo [3];
  int   b_hi [3];
  int   n_wr [3];
  logic signed [15:0] last_d [3];
  int   last_a [3];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
  endtask

  function automatic int qsize(input int i);
    case (i)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t qpop(input int i);
    case (i)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  task automatic qpush(input int i, input exp_t e);
    case (i)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    q2.delete();
    for (int i = 0; i < 3; i++) begin
      exp_done[i] = -1;
      b_lo[i]     = -1000000;
      b_hi[i]     = -1000000;
      n_wr[i]     = 0;
      last_d[i]   = '0;
      last_a[i]   = 0;
    end
  endtask

  // Reference: max over each window of the RAM image, clamped at 0 when ReLU is on.
  task automatic issue(input int i);
    int   t, n, p, m;
    exp_t e;
    t = cyc;
    n = n_in[i];
    p = p_sz[i];
    for (int w = 0; w < n / p; w++) begin
      m = mem[i][w*p];
      for (int k = 1; k < p; k++) if (mem[i][w*p+k] > m) m = mem[i][w*p+k];
      if (relu[i] && m < 0) m = 0;
      e.addr = w;
      e.data = 16'(m);
      e.cyc  = t + 3 + w * p + p - 1;
      qpush(i, e);
    end
    exp_done[i] = t + n + 3;
    b_lo[i]     = t + 1;
    b_hi[i]     = t + n + 3;
    n_wr[i]     = 0;
  endtask

  task automatic mon(input int i, input logic wr, input logic signed [15:0] d, input int a,
                     input logic dn, input logic bz, input int ar);
    exp_t e;
    bit   exp_b;
    exp_b = (cyc >= b_lo[i]) && (cyc <= b_hi[i]);
    chk($sformatf("busy[%0d]", i), bz, exp_b);
    if ((cyc >= b_lo[i]) && (cyc < b_lo[i] + n_in[i])) chk($sformatf("addr_rd[%0d]", i), ar,
                                                           cyc - b_lo[i]);
    else if (!exp_b) chk($sformatf("addr_rd_idle[%0d]", i), ar, 0);
    if (wr) begin
      n_wr[i]++;
      if (qsize(i) == 0) begin
        chk($sformatf("unexpected_wren[%0d]", i), 1, 0);
      end else begin
        e = qpop(i);
        chk($sformatf("wr_addr[%0d]", i), a, e.addr);
        chk($sformatf("wr_data[%0d]", i), d, e.data);
        chk($sformatf("wr_cycle[%0d]", i), cyc, e.cyc);
      end
      last_d[i] = d;
      last_a[i] = a;
    end else begin
      chk($sformatf("hold_data[%0d]", i), d, last_d[i]);
      chk($sformatf("hold_addr[%0d]", i), a, last_a[i]);
    end
    if (dn) begin
      chk($sformatf("done_cycle[%0d]", i), cyc, exp_done[i]);
      chk($sformatf("writes_left_at_done[%0d]", i), qsize(i), 0);
      chk($sformatf("wren_count[%0d]", i), n_wr[i], n_in[i] / p_sz[i]);
      exp_done[i] = -1;
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      mon(0, wr0, dw0, int'(aw0), dn0, bz0, int'(ar0));
      mon(1, wr1, dw1, int'(aw1), dn1, bz1, int'(ar1));
      mon(2, wr2, dw2, int'(aw2), dn2, bz2, int'(ar2));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit all_idle();
    return (exp_done[0] == -1) && (exp_done[1] == -1) && (exp_done[2] == -1) &&
           (q0.size() == 0) && (q1.size() == 0) && (q2.size() == 0);
  endfunction

  task automatic wait_idle(input string name);
    bit idle;
    idle = all_idle();
    for (int k = 0; k < 400 && !idle; k++) begin
      step();
      idle = all_idle();
    end
    chk(name, idle, 1);
    step();
    step();
  endtask

  task automatic zero_chk(input int i, input logic [15:0] d, input int a, input int ar,
                          input logic wr, input logic dn, input logic bz);
    chk($sformatf("rst_data_wr[%0d]", i), d, 0);
    chk($sformatf("rst_addr_wr[%0d]", i), a, 0);
    chk($sformatf("rst_addr_rd[%0d]", i), ar, 0);
    chk($sformatf("rst_wren[%0d]", i), wr, 0);
    chk($sformatf("rst_done[%0d]", i), dn, 0);
    chk($sformatf("rst_busy[%0d]", i), bz, 0);
  endtask

  task automatic zero_all();
    zero_chk(0, dw0, int'(aw0), int'(ar0), wr0, dn0, bz0);
    zero_chk(1, dw1, int'(aw1), int'(ar1), wr1, dn1, bz1);
    zero_chk(2, dw2, int'(aw2), int'(ar2), wr2, dn2, bz2);
  endtask

  task automatic rand_mem(input int i);
    for (int k = 0; k < n_in[i]; k++) begin
      mem[i][k] = 16'($urandom);
      if ($urandom_range(0, 15) == 0) mem[i][k] = 16'sh8000;
      if ($urandom_range(0, 15) == 0) mem[i][k] = 16'sh7fff;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got no end, expected end");
    $fatal(1);
  end

  initial begin
    int d;
    int t;
    logic signed [15:0] init1 [8] = '{16'sd1, 16'sd5, -16'sd3, -16'sd7,
                                      16'sd4, 16'sd4, 16'sd0, -16'sd1};
    logic signed [15:0] init2 [8] = '{-16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768,
                                      16'sd32767, -16'sd1, 16'sd2, 16'sd3};
    logic signed [15:0] init1b [8] = '{-16'sd32768, -16'sd32768, 16'sd7, -16'sd2,
                                       -16'sd5, -16'sd9, 16'sd100, -16'sd100};
    model_reset();
    rst       = 1'b0;
    start_big = 1'b0;
    start_sm  = 1'b0;
    rand_mem(0);
    for (int k = 0; k < 8; k++) begin
      mem[0][k] = init1[k];
      mem[1][k] = init1[k];
      mem[2][k] = init2[k];
    end
    repeat (3) step();
    zero_all();
    rst = 1'b1;
    repeat (2) step();

    // Directed windows on all three instances together
    start_big = 1'b1;
    start_sm  = 1'b1;
    issue(0);
    issue(1);
    issue(2);
    step();
    start_big = 1'b0;
    start_sm  = 1'b0;
    wait_idle("run1_complete");

    // Raw -32768 window, then start in the DONE cycle (ignored) held into the next IDLE cycle
    for (int k = 0; k < 8; k++) mem[1][k] = init1b[k];
    rand_mem(2);
    start_sm = 1'b1;
    issue(1);
    issue(2);
    d = exp_done[1];
    step();
    start_sm = 1'b0;
    while (cyc < d) step();
    start_sm = 1'b1;
    step();
    issue(1);
    issue(2);
    step();
    start_sm = 1'b0;
    wait_idle("run2_complete");

    // start held for 20 cycles gives one run; start right after done gives a second
    rand_mem(0);
    start_big = 1'b1;
    issue(0);
    d = exp_done[0];
    repeat (20) step();
    start_big = 1'b0;
    while (cyc < d + 1) step();
    start_big = 1'b1;
    issue(0);
    step();
    start_big = 1'b0;
    wait_idle("run3_complete");

    // Reset mid-run: outputs clear asynchronously, abandoned run never signals done
    rand_mem(0);
    start_big = 1'b1;
    issue(0);
    t = cyc;
    step();
    start_big = 1'b0;
    while (cyc < t + 5) step();
    #2;
    rst = 1'b0;
    #1;
    zero_all();
    model_reset();
    step();
    step();
    rst = 1'b1;
    repeat (10) step();

    // Full random runs after reset
    for (int r = 0; r < 3; r++) begin
      rand_mem(0);
      rand_mem(1);
      rand_mem(2);
      start_big = 1'b1;
      start_sm  = 1'b1;
      issue(0);
      issue(1);
      issue(2);
      step();
      start_big = 1'b0;
      start_sm  = 1'b0;
      wait_idle("random_run_complete");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
